// File: rtl/ad_ip_jesd204_tpl_dac_pattern_channel.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_pattern_channel
// Brief    : Per-channel DAC transport-layer sample source. Selects among
//            DDS, PN, DMA, ramp and pattern-memory playback, with optional
//            offset-binary conversion and sticky DMA underflow detection.
//            Emits DATA_PATH_WIDTH samples per clock.
// Revision : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_pattern_channel #(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int PAT_DEPTH            = 64,
    localparam int PAT_AW              = $clog2(PAT_DEPTH)
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0]   dma_data,
    input  logic                                         dma_valid,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dds_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn7_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn15_data,
    input  logic                                         dac_data_sync,
    input  logic [3:0]                                   dac_data_sel,
    input  logic                                         dac_mask_enable,
    input  logic                                         dac_pat_format,
    input  logic [CONVERTER_RESOLUTION-1:0]              dac_ramp_init,
    input  logic [CONVERTER_RESOLUTION-1:0]              dac_ramp_step,
    input  logic [PAT_AW:0]                              dac_pat_len,
    input  logic                                         pat_wr_en,
    input  logic [PAT_AW-1:0]                            pat_wr_addr,
    input  logic [CONVERTER_RESOLUTION-1:0]              pat_wr_data,
    input  logic                                         dac_underflow_clr,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dac_data,
    output logic                                         dac_enable,
    output logic                                         dac_underflow
);

    localparam int c_DPW = DATA_PATH_WIDTH;
    localparam int c_CR  = CONVERTER_RESOLUTION;
    localparam int c_BPS = BITS_PER_SAMPLE;
    localparam int c_AW  = PAT_AW;

    localparam logic [3:0] c_SEL_DDS   = 4'h0;
    localparam logic [3:0] c_SEL_ALT   = 4'h1;
    localparam logic [3:0] c_SEL_DMA   = 4'h2;
    localparam logic [3:0] c_SEL_NPN7  = 4'h4;
    localparam logic [3:0] c_SEL_NPN15 = 4'h5;
    localparam logic [3:0] c_SEL_PN7   = 4'h6;
    localparam logic [3:0] c_SEL_PN15  = 4'h7;
    localparam logic [3:0] c_SEL_RAMP  = 4'h8;
    localparam logic [3:0] c_SEL_PLAY  = 4'h9;

    localparam logic [c_AW:0]   c_LEN_MIN  = (c_AW+1)'(c_DPW);
    localparam logic [c_AW:0]   c_LEN_MAX  = (c_AW+1)'(PAT_DEPTH);
    localparam logic [c_CR-1:0] c_MSB      = {1'b1, {(c_CR-1){1'b0}}};
    localparam logic [c_CR-1:0] c_RAMP_ADV = c_CR'(c_DPW);

    logic [c_CR-1:0]       mem_q [PAT_DEPTH];
    logic [c_CR-1:0]       ramp_q, ramp_d, w_ramp_base;
    logic [c_AW:0]         idx_q, idx_d, w_idx_base, w_idx_adv;
    logic [c_AW:0]         w_len_rnd, w_len_eff;
    logic [c_CR-1:0]       w_fmt_mask;
    logic [c_DPW*c_CR-1:0] w_ramp_bus, w_play_bus, w_alt_bus, w_dma_bus;
    logic [c_DPW*c_CR-1:0] dac_data_q, dac_data_d;
    logic                  dac_enable_q, dac_enable_d;
    logic                  dac_underflow_q, dac_underflow_d;
    logic                  w_dma_sel;
    logic                  w_unused_dma;

    // Container MSBs above the converter resolution are intentionally dropped.
    assign w_unused_dma = ^dma_data;
    assign w_fmt_mask   = dac_pat_format ? c_MSB : '0;

    // Pattern memory write port; contents survive reset, reads see old data.
    always_ff @(posedge clk) begin
        if (pat_wr_en) begin
            mem_q[pat_wr_addr] <= pat_wr_data;
        end
    end

    // Effective playback length: whole beats only, at least one beat, at most the memory.
    always_comb begin
        w_len_rnd = (dac_pat_len / c_LEN_MIN) * c_LEN_MIN;
        if (w_len_rnd < c_LEN_MIN) begin
            w_len_eff = c_LEN_MIN;
        end else if (w_len_rnd > c_LEN_MAX) begin
            w_len_eff = c_LEN_MAX;
        end else begin
            w_len_eff = w_len_rnd;
        end
    end

    // Sync overrides the ramp base and playback index in the same cycle so the
    // init lanes appear on the very next output beat.
    always_comb begin
        w_ramp_base = dac_data_sync ? dac_ramp_init : ramp_q;
        ramp_d      = w_ramp_base + c_RAMP_ADV * dac_ramp_step;
        w_idx_base  = dac_data_sync ? '0 : idx_q;
        w_idx_adv   = w_idx_base + c_LEN_MIN;
        idx_d       = (w_idx_adv >= w_len_eff) ? '0 : w_idx_adv;
    end

    // Per-lane source candidates for ramp, playback, alternating pattern and DMA.
    always_comb begin
        w_ramp_bus = '0;
        w_play_bus = '0;
        w_alt_bus  = '0;
        w_dma_bus  = '0;
        for (int i = 0; i < c_DPW; i++) begin
            w_ramp_bus[i*c_CR +: c_CR] = (w_ramp_base + c_CR'(i) * dac_ramp_step) ^ w_fmt_mask;
            w_play_bus[i*c_CR +: c_CR] = mem_q[w_idx_base[c_AW-1:0] + c_AW'(i)] ^ w_fmt_mask;
            w_alt_bus[i*c_CR +: c_CR]  = (((i % 2) == 0) ? mem_q[0] : mem_q[1]) ^ w_fmt_mask;
            w_dma_bus[i*c_CR +: c_CR]  = dma_data[i*c_BPS +: c_CR];
        end
    end

    // Source select, enable and sticky underflow next-state (set beats clear).
    always_comb begin
        w_dma_sel  = dac_mask_enable | (dac_data_sel == c_SEL_DMA);
        dac_data_d = '0;
        if (w_dma_sel) begin
            if (dma_valid) begin
                dac_data_d = w_dma_bus;
            end
        end else begin
            case (dac_data_sel)
                c_SEL_DDS:   dac_data_d = dds_data;
                c_SEL_ALT:   dac_data_d = w_alt_bus;
                c_SEL_NPN7:  dac_data_d = ~pn7_data;
                c_SEL_NPN15: dac_data_d = ~pn15_data;
                c_SEL_PN7:   dac_data_d = pn7_data;
                c_SEL_PN15:  dac_data_d = pn15_data;
                c_SEL_RAMP:  dac_data_d = w_ramp_bus;
                c_SEL_PLAY:  dac_data_d = w_play_bus;
                default:     dac_data_d = '0;
            endcase
        end
        dac_enable_d = (dac_data_sel == c_SEL_DMA) & ~dac_mask_enable;
        if (w_dma_sel & ~dma_valid) begin
            dac_underflow_d = 1'b1;
        end else if (dac_underflow_clr) begin
            dac_underflow_d = 1'b0;
        end else begin
            dac_underflow_d = dac_underflow_q;
        end
    end

    // Output, generator state and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dac_data_q      <= '0;
            dac_enable_q    <= 1'b0;
            dac_underflow_q <= 1'b0;
            ramp_q          <= '0;
            idx_q           <= '0;
        end else begin
            dac_data_q      <= dac_data_d;
            dac_enable_q    <= dac_enable_d;
            dac_underflow_q <= dac_underflow_d;
            ramp_q          <= ramp_d;
            idx_q           <= idx_d;
        end
    end

    assign dac_data      = dac_data_q;
    assign dac_enable    = dac_enable_q;
    assign dac_underflow = dac_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_pattern_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad_ip_jesd204_tpl_dac_pattern_channel
// Brief    : Self-checking bench: vector table plus scoreboard of expected
//            output beats, and hand sequences for multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_ip_jesd204_tpl_dac_pattern_channel;

    localparam int DPW = 4;
    localparam int CR  = 16;
    localparam int BPS = 24;
    localparam int DEP = 64;
    localparam int AW  = 6;

    localparam logic [DPW*BPS-1:0] D1 = {24'h12DEF0, 24'hEF9ABC, 24'hCD5678, 24'hAB1234};
    localparam logic [DPW*BPS-1:0] D2 = {24'h800004, 24'h7F0003, 24'h000002, 24'hFF0001};
    localparam logic [DPW*CR-1:0]  E1 = 64'hDEF0_9ABC_5678_1234;
    localparam logic [DPW*CR-1:0]  E2 = 64'h0004_0003_0002_0001;
    localparam logic [DPW*CR-1:0]  DDS  = 64'h4444_3333_2222_1111;
    localparam logic [DPW*CR-1:0]  PN7  = 64'hF0F0_0F0F_5A5A_A5A5;
    localparam logic [DPW*CR-1:0]  PN15 = 64'hACE0_9BDF_2468_1357;
    localparam logic [DPW*CR-1:0]  Z    = '0;

    logic                clk = 1'b0;
    logic                resetn;
    logic [DPW*BPS-1:0]  dma_data;
    logic                dma_valid;
    logic [DPW*CR-1:0]   dds_data, pn7_data, pn15_data;
    logic                dac_data_sync;
    logic [3:0]          dac_data_sel;
    logic                dac_mask_enable, dac_pat_format;
    logic [CR-1:0]       dac_ramp_init, dac_ramp_step;
    logic [AW:0]         dac_pat_len;
    logic                pat_wr_en;
    logic [AW-1:0]       pat_wr_addr;
    logic [CR-1:0]       pat_wr_data;
    logic                dac_underflow_clr;
    logic [DPW*CR-1:0]   dac_data;
    logic                dac_enable, dac_underflow;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_pattern_channel #(
        .DATA_PATH_WIDTH      (DPW),
        .CONVERTER_RESOLUTION (CR),
        .BITS_PER_SAMPLE      (BPS),
        .PAT_DEPTH            (DEP)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .dma_data          (dma_data),
        .dma_valid         (dma_valid),
        .dds_data          (dds_data),
        .pn7_data          (pn7_data),
        .pn15_data         (pn15_data),
        .dac_data_sync     (dac_data_sync),
        .dac_data_sel      (dac_data_sel),
        .dac_mask_enable   (dac_mask_enable),
        .dac_pat_format    (dac_pat_format),
        .dac_ramp_init     (dac_ramp_init),
        .dac_ramp_step     (dac_ramp_step),
        .dac_pat_len       (dac_pat_len),
        .pat_wr_en         (pat_wr_en),
        .pat_wr_addr       (pat_wr_addr),
        .pat_wr_data       (pat_wr_data),
        .dac_underflow_clr (dac_underflow_clr),
        .dac_data          (dac_data),
        .dac_enable        (dac_enable),
        .dac_underflow     (dac_underflow)
    );

    typedef struct {
        string              name;
        logic [3:0]         sel;
        logic               mask, sync, fmt, valid, clr;
        logic [AW:0]        len;
        logic [CR-1:0]      init, step;
        logic [DPW*BPS-1:0] dma;
        logic [DPW*CR-1:0]  exp;
        logic               en, uf;
    } vec_t;

    typedef struct {
        string              name;
        logic [DPW*CR-1:0]  data;
        logic               en, uf;
        bit                 chk;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic logic [63:0] p4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] seq4(input logic [15:0] b);
        return p4(b, b + 16'd1, b + 16'd2, b + 16'd3);
    endfunction

    function automatic vec_t mk(input string name, input logic [3:0] sel, input logic mask,
                                input logic sync, input logic fmt, input logic [AW:0] len,
                                input logic [CR-1:0] init, input logic [CR-1:0] step,
                                input logic valid, input logic clr, input logic [DPW*BPS-1:0] dma,
                                input logic [DPW*CR-1:0] exp, input logic en, input logic uf);
        vec_t v;
        v.name = name; v.sel = sel; v.mask = mask; v.sync = sync; v.fmt = fmt;
        v.len = len; v.init = init; v.step = step; v.valid = valid; v.clr = clr;
        v.dma = dma; v.exp = exp; v.en = en; v.uf = uf;
        return v;
    endfunction

    task automatic push_exp(input string name, input logic [63:0] d, input logic en,
                            input logic uf, input bit chk);
        exp_t e;
        e.name = name; e.data = d; e.en = en; e.uf = uf; e.chk = chk;
        sb.push_back(e);
    endtask

    // One clock: the beat captured at this edge is popped and compared.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_empty: output beat arrived with nothing expected");
        end else begin
            e = sb.pop_front();
            if (e.chk) begin
                nvec++;
                if (dac_data !== e.data || dac_enable !== e.en || dac_underflow !== e.uf) begin
                    nmis++;
                    $display("FAIL %s: got data=%h en=%b uf=%b, want data=%h en=%b uf=%b",
                             e.name, dac_data, dac_enable, dac_underflow, e.data, e.en, e.uf);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        dma_data = '0; dma_valid = 1'b1;
        dds_data = DDS; pn7_data = PN7; pn15_data = PN15;
        dac_data_sync = 1'b0; dac_data_sel = 4'h3; dac_mask_enable = 1'b0;
        dac_pat_format = 1'b0; dac_ramp_init = '0; dac_ramp_step = '0;
        dac_pat_len = 7'd12; pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
        dac_underflow_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (dac_data !== Z || dac_enable !== 1'b0 || dac_underflow !== 1'b0) begin
            nmis++;
            $display("FAIL reset: got data=%h en=%b uf=%b, want all zero",
                     dac_data, dac_enable, dac_underflow);
        end
        resetn = 1'b1;

        // Load mem[k] = k.
        for (int k = 0; k < DEP; k++) begin
            pat_wr_en = 1'b1; pat_wr_addr = AW'(k); pat_wr_data = CR'(k);
            push_exp("mem_load", Z, 1'b0, 1'b0, 1'b0);
            tick();
        end
        pat_wr_en = 1'b0;

        //        name             sel mask sync fmt len   init      step     vld clr dma exp                                  en uf
        vt.push_back(mk("ramp_sync",    4'h8, 0, 1, 0, 7'd12, 16'h0010, 16'h0002, 1, 0, D1, p4(16'h10,16'h12,16'h14,16'h16), 0, 0));
        vt.push_back(mk("ramp_adv1",    4'h8, 0, 0, 0, 7'd12, 16'h0010, 16'h0002, 1, 0, D1, p4(16'h18,16'h1A,16'h1C,16'h1E), 0, 0));
        vt.push_back(mk("ramp_adv2",    4'h8, 0, 0, 0, 7'd12, 16'h0010, 16'h0002, 1, 0, D1, p4(16'h20,16'h22,16'h24,16'h26), 0, 0));
        vt.push_back(mk("ramp_wsync",   4'h8, 0, 1, 0, 7'd12, 16'hFFFC, 16'h0001, 1, 0, D1, seq4(16'hFFFC), 0, 0));
        vt.push_back(mk("ramp_wrap",    4'h8, 0, 0, 0, 7'd12, 16'hFFFC, 16'h0001, 1, 0, D1, seq4(16'h0000), 0, 0));
        vt.push_back(mk("ramp_hold_a",  4'h8, 0, 1, 0, 7'd12, 16'hFFFC, 16'h0001, 1, 0, D1, seq4(16'hFFFC), 0, 0));
        vt.push_back(mk("ramp_hold_b",  4'h8, 0, 1, 0, 7'd12, 16'hFFFC, 16'h0001, 1, 0, D1, seq4(16'hFFFC), 0, 0));
        vt.push_back(mk("ramp_release", 4'h8, 0, 0, 0, 7'd12, 16'hFFFC, 16'h0001, 1, 0, D1, seq4(16'h0000), 0, 0));
        vt.push_back(mk("p12_sync",     4'h9, 0, 1, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p12_w1",       4'h9, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd4), 0, 0));
        vt.push_back(mk("p12_w2",       4'h9, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd8), 0, 0));
        vt.push_back(mk("p12_wrap",     4'h9, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p12_w1b",      4'h9, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd4), 0, 0));
        vt.push_back(mk("p14_sync",     4'h9, 0, 1, 0, 7'd14, 16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p14_w1",       4'h9, 0, 0, 0, 7'd14, 16'h0, 16'h0, 1, 0, D1, seq4(16'd4), 0, 0));
        vt.push_back(mk("p14_w2",       4'h9, 0, 0, 0, 7'd14, 16'h0, 16'h0, 1, 0, D1, seq4(16'd8), 0, 0));
        vt.push_back(mk("p14_wrap",     4'h9, 0, 0, 0, 7'd14, 16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p0_sync",      4'h9, 0, 1, 0, 7'd0,  16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p0_rep1",      4'h9, 0, 0, 0, 7'd0,  16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("p0_rep2",      4'h9, 0, 0, 0, 7'd0,  16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("chg_sync",     4'h9, 0, 1, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("chg_w1",       4'h9, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, seq4(16'd4), 0, 0));
        vt.push_back(mk("chg_short",    4'h9, 0, 0, 0, 7'd4,  16'h0, 16'h0, 1, 0, D1, seq4(16'd8), 0, 0));
        vt.push_back(mk("chg_restart",  4'h9, 0, 0, 0, 7'd4,  16'h0, 16'h0, 1, 0, D1, seq4(16'd0), 0, 0));
        vt.push_back(mk("alt_fmt",      4'h1, 0, 0, 1, 7'd12, 16'h0, 16'h0, 1, 0, D1, p4(16'h8000,16'h8001,16'h8000,16'h8001), 0, 0));
        vt.push_back(mk("alt_raw",      4'h1, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, p4(16'h0,16'h1,16'h0,16'h1), 0, 0));
        vt.push_back(mk("pn7_fmt",      4'h6, 0, 0, 1, 7'd12, 16'h0, 16'h0, 1, 0, D1, PN7, 0, 0));
        vt.push_back(mk("npn7_fmt",     4'h4, 0, 0, 1, 7'd12, 16'h0, 16'h0, 1, 0, D1, ~PN7, 0, 0));
        vt.push_back(mk("pn15",         4'h7, 0, 0, 1, 7'd12, 16'h0, 16'h0, 1, 0, D1, PN15, 0, 0));
        vt.push_back(mk("npn15",        4'h5, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, ~PN15, 0, 0));
        vt.push_back(mk("dds",          4'h0, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, DDS, 0, 0));
        vt.push_back(mk("play_fmt",     4'h9, 0, 1, 1, 7'd12, 16'h0, 16'h0, 1, 0, D1, p4(16'h8000,16'h8001,16'h8002,16'h8003), 0, 0));
        vt.push_back(mk("ramp_fmt",     4'h8, 0, 1, 1, 7'd12, 16'h0010, 16'h0002, 1, 0, D1, p4(16'h8010,16'h8012,16'h8014,16'h8016), 0, 0));
        vt.push_back(mk("dma_d1",       4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, E1, 1, 0));
        vt.push_back(mk("dma_under",    4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 0, 0, D1, Z,  1, 1));
        vt.push_back(mk("dma_sticky",   4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D2, E2, 1, 1));
        vt.push_back(mk("dma_set_wins", 4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 0, 1, D2, Z,  1, 1));
        vt.push_back(mk("dma_clear",    4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 1, D1, E1, 1, 0));
        vt.push_back(mk("dma_d2",       4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D2, E2, 1, 0));
        vt.push_back(mk("mask_ramp",    4'h8, 1, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, E1, 0, 0));
        vt.push_back(mk("mask_under",   4'h8, 1, 0, 0, 7'd12, 16'h0, 16'h0, 0, 0, D1, Z,  0, 1));
        vt.push_back(mk("unmask_dma",   4'h2, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 1, D2, E2, 1, 0));
        vt.push_back(mk("sel_zero",     4'h3, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, Z,  0, 0));
        vt.push_back(mk("sel_c",        4'hC, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, Z,  0, 0));
        vt.push_back(mk("sel_a",        4'hA, 0, 0, 0, 7'd12, 16'h0, 16'h0, 1, 0, D1, Z,  0, 0));
        vt.push_back(mk("nodma_invld",  4'h3, 0, 0, 0, 7'd12, 16'h0, 16'h0, 0, 0, D1, Z,  0, 0));

        for (int k = 0; k < vt.size(); k++) begin
            dac_data_sel = vt[k].sel; dac_mask_enable = vt[k].mask;
            dac_data_sync = vt[k].sync; dac_pat_format = vt[k].fmt;
            dac_pat_len = vt[k].len; dac_ramp_init = vt[k].init;
            dac_ramp_step = vt[k].step; dma_valid = vt[k].valid;
            dac_underflow_clr = vt[k].clr; dma_data = vt[k].dma;
            push_exp(vt[k].name, vt[k].exp, vt[k].en, vt[k].uf, 1'b1);
            tick();
        end
        dma_valid = 1'b1; dac_underflow_clr = 1'b0; dac_pat_format = 1'b0;
        dac_data_sync = 1'b0; dac_mask_enable = 1'b0;

        // Over-long length clamps to the full memory: 16 beats then wrap.
        dac_data_sel = 4'h9; dac_pat_len = 7'd127;
        for (int k = 0; k < 17; k++) begin
            dac_data_sync = (k == 0);
            push_exp("play_clamp", seq4(16'((k % 16) * 4)), 1'b0, 1'b0, 1'b1);
            tick();
        end
        dac_data_sync = 1'b0;

        // Same-address read and write returns old data, new data next beat.
        dac_data_sel = 4'h1;
        pat_wr_en = 1'b1; pat_wr_addr = '0; pat_wr_data = 16'h5555;
        push_exp("rw_old", p4(16'h0, 16'h1, 16'h0, 16'h1), 1'b0, 1'b0, 1'b1);
        tick();
        pat_wr_en = 1'b0;
        push_exp("rw_new", p4(16'h5555, 16'h1, 16'h5555, 16'h1), 1'b0, 1'b0, 1'b1);
        tick();
        dac_data_sel = 4'h3; pat_wr_en = 1'b1; pat_wr_data = 16'h0000;
        push_exp("rw_restore", Z, 1'b0, 1'b0, 1'b1);
        tick();
        pat_wr_en = 1'b0;

        // Asynchronous reset in the middle of playback.
        dac_data_sel = 4'h9; dac_pat_len = 7'd12; dac_data_sync = 1'b1;
        push_exp("rst_pre0", seq4(16'd0), 1'b0, 1'b0, 1'b1);
        tick();
        dac_data_sync = 1'b0;
        push_exp("rst_pre1", seq4(16'd4), 1'b0, 1'b0, 1'b1);
        tick();
        resetn = 1'b0;
        #1;
        nvec++;
        if (dac_data !== Z || dac_enable !== 1'b0 || dac_underflow !== 1'b0) begin
            nmis++;
            $display("FAIL async_reset: got data=%h en=%b uf=%b, want all zero",
                     dac_data, dac_enable, dac_underflow);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_exp("rst_post0", seq4(16'd0), 1'b0, 1'b0, 1'b1);
        tick();
        push_exp("rst_post1", seq4(16'd4), 1'b0, 1'b0, 1'b1);
        tick();

        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_leftover: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
